dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter and sequencer for the single-port data memory.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the
// single-port data memory. Port 0 is the load/store unit, port 1 the
// debug/DMA loader. One access is granted per cycle. Read responses return
// one cycle after the grant. Out-of-range accesses are answered with an
// error and never reach the memory. One memory-clear cycle follows reset.
module dmem_arbiter #(
  parameter int DEPTH = 41,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,            // asynchronous, active-low
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_reset,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_signal,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_e state_q, state_d;
  logic   last_q, last_d;       // port granted most recently; loses the next tie
  logic   rv0_q, rv0_d, er0_q, er0_d;
  logic   rv1_q, rv1_d, er1_q, er1_d;

  // Unsigned full-width range check; no wrap-around of large addresses.
  logic oor0, oor1;
  assign oor0 = (p0_addr >= DEPTH_A);
  assign oor1 = (p1_addr >= DEPTH_A);

  // State, tie-break history and registered response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      er0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      er1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      er0_q   <= er0_d;
      rv1_q   <= rv1_d;
      er1_q   <= er1_d;
    end
  end

  // Next state, arbitration and memory command drive.
  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    p0_gnt           = 1'b0;
    p1_gnt           = 1'b0;
    rv0_d            = 1'b0;
    er0_d            = 1'b0;
    rv1_d            = 1'b0;
    er1_d            = 1'b0;
    mem_reset        = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_signal = 1'b0;
    case (state_q)
      INIT: begin
        mem_reset = 1'b1;
        state_d   = RUN;
      end
      default: begin
        // Port 0 wins when alone or when port 1 was the last winner.
        if (p0_req && (!p1_req || last_q)) begin
          p0_gnt = 1'b1;
          last_d = 1'b0;
          rv0_d  = !p0_we || oor0;
          er0_d  = oor0;
          if (!oor0) begin
            mem_address      = p0_addr;
            mem_write_data   = p0_wdata;
            mem_write_signal = p0_we;
          end
        end else if (p1_req) begin
          p1_gnt = 1'b1;
          last_d = 1'b1;
          rv1_d  = !p1_we || oor1;
          er1_d  = oor1;
          if (!oor1) begin
            mem_address      = p1_addr;
            mem_write_data   = p1_wdata;
            mem_write_signal = p1_we;
          end
        end
      end
    endcase
  end

  assign p0_rvalid = rv0_q;
  assign p0_err    = er0_q;
  assign p1_rvalid = rv1_q;
  assign p1_err    = er1_q;

  // Read data comes straight from the memory's output register; error
  // responses and idle cycles present zero.
  assign p0_rdata = (rv0_q && !er0_q) ? mem_read_data : '0;
  assign p1_rdata = (rv1_q && !er1_q) ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural registered-read memory, directed
// accesses with expected responses queued per port, and a monitor that
// pops and compares whenever a port presents rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_reset, mem_write_signal;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_arbiter #(.DEPTH(41), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_reset(mem_reset), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_signal(mem_write_signal),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with registered read and a clear input.
  logic [31:0] mem_arr [0:63];
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
      mem_read_data <= '0;
    end else begin
      if (mem_write_signal) mem_arr[mem_address[5:0]] <= mem_write_data;
      mem_read_data <= mem_arr[mem_address[5:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expectation for
  // that port and arrive exactly one cycle after its grant.
  always @(negedge clk) begin
    exp_t it;
    if (p0_rvalid) begin
      if (q0.size() == 0) chk("p0_spurious_rvalid", 32'd1, 32'd0);
      else begin
        it = q0.pop_front();
        chk("p0_latency", cyc, it.due);
        chk("p0_rdata", p0_rdata, it.d);
        chk("p0_err", p0_err, {31'd0, it.e});
        $display("rsp p0 rdata=%h err=%0d", p0_rdata, p0_err);
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      chk("p0_missing_rvalid", 32'd0, 32'd1);
      void'(q0.pop_front());
    end
    if (p1_rvalid) begin
      if (q1.size() == 0) chk("p1_spurious_rvalid", 32'd1, 32'd0);
      else begin
        it = q1.pop_front();
        chk("p1_latency", cyc, it.due);
        chk("p1_rdata", p1_rdata, it.d);
        chk("p1_err", p1_err, {31'd0, it.e});
        $display("rsp p1 rdata=%h err=%0d", p1_rdata, p1_err);
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      chk("p1_missing_rvalid", 32'd0, 32'd1);
      void'(q1.pop_front());
    end
  end

  task automatic push_exp(input int p, input logic [31:0] d, input logic e);
    exp_t it;
    it.due = cyc + 1;
    it.d   = d;
    it.e   = e;
    if (p == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  task automatic set_req(input int p, input logic rq, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  // One access on one port: request until granted (bounded), check the
  // memory command in the grant cycle and queue the expected response.
  task automatic acc(input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic exp_err);
    logic got = 1'b0;
    logic g, og;
    set_req(p, 1'b1, we, a, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      g  = (p == 0) ? p0_gnt : p1_gnt;
      og = (p == 0) ? p1_gnt : p0_gnt;
      if (g) begin
        got = 1'b1;
        $display("txn p%0d we=%0d addr=%h wdata=%h", p, we, a, d);
        chk("gnt_exclusive", og, 32'd0);
        chk("mem_reset_run", mem_reset, 32'd0);
        chk("mem_address", mem_address, exp_err ? 32'd0 : a);
        chk("mem_write_signal", mem_write_signal, {31'd0, we && !exp_err});
        if (we && !exp_err) chk("mem_write_data", mem_write_data, d);
        if (!we || exp_err) push_exp(p, exp_d, exp_err);
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_timeout: port %0d addr %h got no gnt", p, a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'd5, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state with a request already pending.
    chk("rst_mem_reset", mem_reset, 32'd1);
    chk("rst_p0_gnt", p0_gnt, 32'd0);
    chk("rst_p0_rvalid", p0_rvalid, 32'd0);
    chk("rst_p1_rvalid", p1_rvalid, 32'd0);
    chk("rst_mem_ws", mem_write_signal, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);

    // 1: one INIT cycle, no grant, then a read of word 5 returns 0.
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("init_mem_reset", mem_reset, 32'd1);
    chk("init_p0_gnt", p0_gnt, 32'd0);
    chk("init_mem_ws", mem_write_signal, 32'd0);
    @(posedge clk); #1;
    acc(0, 1'b0, 32'd5, 32'd0, 32'd0, 1'b0);

    // 2: write then read back through port 0.
    acc(0, 1'b1, 32'd3, 32'hDEADBEEF, 32'd0, 1'b0);
    acc(0, 1'b0, 32'd3, 32'd0, 32'hDEADBEEF, 1'b0);

    // Setup words for the round-robin test; last write from p1.
    for (int i = 10; i < 13; i++) acc(0, 1'b1, i, 32'hA000_0000 + i, 32'd0, 1'b0);
    for (int i = 20; i < 23; i++) acc(1, 1'b1, i, 32'hB000_0000 + i, 32'd0, 1'b0);

    // 3: both ports request reads continuously; grants alternate from p0.
    begin
      int i0 = 0;
      int i1 = 0;
      set_req(0, 1'b1, 1'b0, 32'd10, 32'd0);
      set_req(1, 1'b1, 1'b0, 32'd20, 32'd0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("rr_p0_gnt", p0_gnt, {31'd0, (i % 2) == 0});
        chk("rr_p1_gnt", p1_gnt, {31'd0, (i % 2) == 1});
        if (p0_gnt) begin
          $display("txn p0 we=0 addr=%h (rr)", p0_addr);
          push_exp(0, 32'hA000_0000 + p0_addr, 1'b0);
          i0++;
        end
        if (p1_gnt) begin
          $display("txn p1 we=0 addr=%h (rr)", p1_addr);
          push_exp(1, 32'hB000_0000 + p1_addr, 1'b0);
          i1++;
        end
        @(posedge clk); #1;
        p0_addr = 32'd10 + i0;
        p1_addr = 32'd20 + i1;
      end
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // 4: out-of-range accesses, plus the last legal word.
    acc(0, 1'b1, 32'd0, 32'h0000_55AA, 32'd0, 1'b0);
    acc(1, 1'b1, 32'd41, 32'h1111_2222, 32'd0, 1'b1);
    acc(1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    acc(0, 1'b0, 32'd0, 32'd0, 32'h0000_55AA, 1'b0);
    acc(0, 1'b1, 32'd40, 32'h4040_4040, 32'd0, 1'b0);
    acc(1, 1'b0, 32'd40, 32'd0, 32'h4040_4040, 1'b0);

    // 5: p0 reads word 7 in cycle N, p1 overwrites it in N+1.
    acc(0, 1'b1, 32'd7, 32'h0000_7777, 32'd0, 1'b0);
    set_req(0, 1'b1, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    chk("t5_p0_gnt", p0_gnt, 32'd1);
    if (p0_gnt) push_exp(0, 32'h0000_7777, 1'b0);
    $display("txn p0 we=0 addr=00000007 (interleave)");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b1, 32'd7, 32'h0000_1234);
    @(negedge clk);
    chk("t5_p1_gnt", p1_gnt, 32'd1);
    chk("t5_mem_ws", mem_write_signal, 32'd1);
    $display("txn p1 we=1 addr=00000007 wdata=00001234 (interleave)");
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    acc(0, 1'b0, 32'd7, 32'd0, 32'h0000_1234, 1'b0);

    // 6: reset right after a read grant drops the response and clears memory.
    set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
    @(negedge clk);
    chk("t6_p0_gnt", p0_gnt, 32'd1);
    $display("txn p0 we=0 addr=00000003 (aborted by reset)");
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t6_no_rvalid", p0_rvalid, 32'd0);
    chk("t6_mem_reset", mem_reset, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_init_mem_reset", mem_reset, 32'd1);
    @(posedge clk); #1;
    acc(0, 1'b0, 32'd3, 32'd0, 32'd0, 1'b0);
    acc(1, 1'b0, 32'd22, 32'd0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
